// File: rtl/deco_pkg.sv
// Shared types for the decoded-instruction queue: instruction class, the
// 63-bit decoded bundle, condition-code encodings and the NZCV evaluator.
package deco_pkg;

  typedef enum logic [1:0] {
    CLS_DP    = 2'b00,
    CLS_MEM   = 2'b01,
    CLS_BR    = 2'b10,
    CLS_UNDEF = 2'b11
  } cls_t;

  typedef struct packed {
    cls_t        cls;
    logic [3:0]  cond;
    logic        i;
    logic [3:0]  opcode;
    logic        s;
    logic        p;
    logic        u;
    logic        b;
    logic        w;
    logic        l;
    logic        link;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] imm12;
    logic [23:0] off24;
    logic        undef;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // nzcv ordering: N in bit 3, Z bit 2, C bit 1, V bit 0.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/deco_fields.sv
// Combinational field extractor: raw 32-bit instruction word to dec_t.
// Fields that the instruction class does not define are forced to zero.
module deco_fields
  import deco_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  cls_t cls;

  assign cls = cls_t'(instr_i[27:26]);

  always_comb begin
    // NOTE: the all-zero default on every path keeps this purely combinational (no latch) and gives undefined fields a known 0.
    dec_o      = '0;
    dec_o.cls  = cls;
    dec_o.cond = instr_i[31:28];
    unique case (cls)
      CLS_DP: begin
        dec_o.i      = instr_i[25];
        dec_o.opcode = instr_i[24:21];
        dec_o.s      = instr_i[20];
        dec_o.rn     = instr_i[19:16];
        dec_o.rd     = instr_i[15:12];
        dec_o.imm12  = instr_i[11:0];
      end
      CLS_MEM: begin
        dec_o.i     = instr_i[25];
        dec_o.p     = instr_i[24];
        dec_o.u     = instr_i[23];
        dec_o.b     = instr_i[22];
        dec_o.w     = instr_i[21];
        dec_o.l     = instr_i[20];
        dec_o.rn    = instr_i[19:16];
        dec_o.rd    = instr_i[15:12];
        dec_o.imm12 = instr_i[11:0];
      end
      CLS_BR: begin
        dec_o.link  = instr_i[24];
        dec_o.off24 = instr_i[23:0];
      end
      CLS_UNDEF: begin
        dec_o.undef = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/deco_queue.sv
// Decoded-instruction FIFO: words are decoded on write and stored as dec_t.
// Define DECO_COND_EVAL_EN to evaluate the head condition code against flags.
module deco_queue
  import deco_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output dec_t                   out_dec,
  output logic                   out_cond_pass,
  input  logic [3:0]             flags,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  dec_t          out_dec_q, out_dec_d;
  dec_t          mem_q [DEPTH];
  dec_t          dec_in;
  logic          push, pop;

  deco_fields u_fields (
    .instr_i (in_instr),
    .dec_o   (dec_in)
  );

  // Handshakes are gated by rst_n so both read low throughout a reset cycle.
  assign in_ready  = rst_n && (count_q < DEPTH_C) && !flush;
  assign out_valid = rst_n && (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    out_dec_d = out_dec_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // Registered head: the new head is either a stored entry or the word
      // being written this cycle; an empty queue keeps the last head value.
      if (count_d != '0) begin
        if (push && (rd_ptr_d == wr_ptr_q)) out_dec_d = dec_in;
        else                                out_dec_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_dec_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      out_dec_q <= out_dec_d;
    end
  end

  // NOTE: the entry array has no reset; an entry is only read after being written, and out_dec comes from the reset head register.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_in;
  end

  assign out_dec = out_dec_q;
  assign count   = count_q;

`ifdef DECO_COND_EVAL_EN
  assign out_cond_pass = cond_pass(out_dec_q.cond, flags);
`else
  logic unused_flags;
  assign unused_flags  = ^flags;
  assign out_cond_pass = 1'b1;
`endif

endmodule

// File: doc/deco_queue.md
DECO_QUEUE -- requirements
Module: deco_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of decoded-instruction entries; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  instruction word offered.
REQ-005 in_ready  output  1  queue can accept the word this cycle.
REQ-006 in_instr  input  32  raw instruction word.
REQ-007 out_valid  output  1  head entry is valid.
REQ-008 out_ready  input  1  consumer takes the head entry this cycle.
REQ-009 out_dec  output  63  decoded bundle of type deco_pkg::dec_t at the head.
REQ-010 out_cond_pass  output  1  head condition code evaluates true against flags.
REQ-011 flags  input  4  current NZCV flags, N in bit 3.
REQ-012 flush  input  1  discard all entries.
REQ-013 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 Class = in_instr[27:26]: 00 data-processing, 01 single transfer, 10 branch, 11 undefined.
REQ-015 All classes: cond=[31:28], cls=[27:26].
REQ-016 Data-processing: i=[25], opcode=[24:21], s=[20], rn=[19:16], rd=[15:12], imm12=[11:0].
REQ-017 Single transfer: i=[25], p=[24], u=[23], b=[22], w=[21], l=[20], rn, rd, imm12=[11:0].
REQ-018 Branch: link=[24], off24=[23:0]; bit 25 is ignored.
REQ-019 Class 11: undef=1; all other fields except cond and cls are 0.
REQ-020 Fields not defined for a class are 0, never X.
REQ-021 Decode is performed at write; entries store dec_t, not the raw word.
REQ-022 A push occurs when in_valid&&in_ready; in_ready = (count<DEPTH) && !flush.
REQ-023 A pop occurs when out_valid&&out_ready; out_valid = (count!=0).
REQ-024 Latency: a word pushed in cycle N is visible at out_dec in cycle N+1 at the earliest.
REQ-025 Order is FIFO; read and write pointers wrap modulo DEPTH.
REQ-026 Simultaneous push and pop when 0<count<DEPTH leaves count unchanged.
REQ-027 When full, a same-cycle pop does not make in_ready high; in_ready rises the following cycle.
REQ-028 When empty, out_dec holds its last value and must be ignored by the consumer.
REQ-029 flush sets count=0 and both pointers to 0 next cycle; any same-cycle push and pop are discarded.
REQ-030 Condition table:
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
- AL 1; 1111 gives 0
- Evaluated combinationally from the head entry and the current flags.

Reset
REQ-031 While rst_n=0 at a rising edge: count=0, pointers=0, out_valid=0, in_ready=0 during that reset cycle; out_dec=0.
REQ-032 Reset asserted mid-operation drops all entries with no partial pop or push.

Configuration
REQ-033 With DECO_COND_EVAL_EN defined, out_cond_pass follows REQ-030.
REQ-034 Without DECO_COND_EVAL_EN, out_cond_pass is constant 1 and flags is unused.

Structure
REQ-035 deco_pkg holds:
- cls_t enum (CLS_DP, CLS_MEM, CLS_BR, CLS_UNDEF)
- dec_t packed struct: cls, cond, i, opcode, s, p, u, b, w, l, link, rn, rd, imm12, off24, undef = 63 bits
- condition encoding constants
REQ-036 Combinational sub-module deco_fields maps 32-bit word to dec_t; deco_queue instantiates it once on the write path.

Verification (DEPTH=4)
REQ-037 Push 0xE0812003 -> next cycle:
- cls=00, cond=E, opcode=0100, rn=1, rd=2, imm12=003
- p=u=b=w=l=link=undef=0, off24=0.
REQ-038 Push 0xE5912004, 0xEB000010, 0xEC000000 ->
- entry 1: cls=01, p=1, u=1, b=0, w=0, l=1, rn=1, rd=2, imm12=004
- entry 2: cls=10, link=1, off24=000010
- entry 3: undef=1, remaining fields 0.
REQ-039 out_ready=0, push 5 words -> count=4, in_ready=0, 5th word held; one pop -> in_ready=1 next cycle; FIFO order preserved after pointer wrap.
REQ-040 count=2 plus simultaneous push, pop and flush -> count=0 and out_valid=0 next cycle; rst_n=0 with count=3 -> count=0 next cycle.
REQ-041 Head cond=0000:
- flags=0100 -> out_cond_pass=1
- flags=0000 -> 0
- cond=1111 -> 0
- DECO_COND_EVAL_EN undefined -> always 1.
